// File: rtl/rfdp_pkg.sv
// Shared types and elaboration helpers for the rfdp FIFO family.
package rfdp_pkg;

   typedef logic [1:0] ocnt_t;

   // Address width that never collapses to zero bits for tiny depths.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      for (int unsigned i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = int'(i) + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/xilinx_1w1r_sram.sv
// One-write/one-read SRAM model, read latency 1, active-low port enables.
module xilinx_1w1r_sram
   import rfdp_pkg::*;
#(
   parameter int WWORD = 256,
   parameter int WADDR = 7,
   parameter int DEPTH = 128
) (
   input  logic             clka,
   input  logic             cena,
   input  logic [WADDR-1:0] aa,
   input  logic [WWORD-1:0] da,
   input  logic             clkb,
   input  logic             cenb,
   input  logic [WADDR-1:0] ab,
   output logic [WWORD-1:0] qb
);

   logic [WWORD-1:0] mem [DEPTH];

   always_ff @(posedge clka) begin
      if (!cena) mem[aa] <= da;
   end

   always_ff @(posedge clkb) begin
      if (!cenb) qb <= mem[ab];
   end

endmodule

// File: rtl/rfdp_fifo.sv
// FWFT FIFO over a latency-1 SRAM with a 2-entry prefetch stage,
// occupancy/almost-full flags, high-water mark and synchronous flush.
module rfdp_fifo
   import rfdp_pkg::*;
#(
   parameter int   WIDTH     = 256,
   parameter int   DEPTH     = 128,
   parameter int   AF_THRESH = DEPTH - 8,
   localparam int  LVL_W     = $clog2(DEPTH + 3)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic [LVL_W-1:0] level,
   output logic             almost_full,
   output logic [LVL_W-1:0] max_level
);

   localparam int ADDR_W = clog2_min1(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  FULL = CNT_W'(DEPTH);

   if (DEPTH < 2) begin : g_depth_chk
      $error("rfdp_fifo: DEPTH must be at least 2");
   end

   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  mem_cnt, mem_cnt_n;
   ocnt_t             out_cnt, out_cnt_n, held;
   logic              rd_inflight, rd_issue, push, pop, cena, cenb;
   logic [WIDTH-1:0]  ent0, ent1, ent0_n, ent1_n, rdata;
   logic [LVL_W-1:0]  level_n;

   assign s_ready = (mem_cnt < FULL) & ~flush & rst_n;
   assign m_valid = (out_cnt != 2'd0);
   assign m_data  = ent0;
   assign push    = s_valid & s_ready;
   assign pop     = m_valid & m_ready;
   assign held    = out_cnt - ocnt_t'(pop);
   assign cena    = ~push;
   assign cenb    = ~rd_issue;

   // Issue only while the stage can absorb the return after this edge's pop.
   assign rd_issue = (mem_cnt != '0) & rst_n & ~flush &
                     ((held == 2'd0) | ((held == 2'd1) & ~rd_inflight));

   always_comb begin
      ent0_n    = ent0;
      ent1_n    = ent1;
      out_cnt_n = held + ocnt_t'(rd_inflight);
      if (pop && (out_cnt == 2'd2)) ent0_n = ent1;
      if (rd_inflight) begin
         if (held == 2'd0) ent0_n = rdata;
         else              ent1_n = rdata;
      end
      mem_cnt_n = mem_cnt + CNT_W'(push) - CNT_W'(rd_issue);
      level_n   = LVL_W'(mem_cnt_n) + LVL_W'(out_cnt_n) + LVL_W'(rd_issue);
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         mem_cnt     <= '0;
         out_cnt     <= '0;
         rd_inflight <= 1'b0;
         level       <= '0;
         max_level   <= '0;
         almost_full <= 1'b0;
         if (!rst_n) begin
            ent0 <= '0;
            ent1 <= '0;
         end
      end else begin
         if (push)     wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + ADDR_W'(1);
         if (rd_issue) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + ADDR_W'(1);
         mem_cnt     <= mem_cnt_n;
         out_cnt     <= out_cnt_n;
         rd_inflight <= rd_issue;
         ent0        <= ent0_n;
         ent1        <= ent1_n;
         level       <= level_n;
         almost_full <= (int'(level_n) >= AF_THRESH);
         if (level_n > max_level) max_level <= level_n;
      end
   end

   xilinx_1w1r_sram #(
      .WWORD(WIDTH),
      .WADDR(ADDR_W),
      .DEPTH(DEPTH)
   ) u_sram (
      .clka(clk),
      .cena(cena),
      .aa  (wr_ptr),
      .da  (s_data),
      .clkb(clk),
      .cenb(cenb),
      .ab  (rd_ptr),
      .qb  (rdata)
   );

endmodule

// File: tb/tb_rfdp_fifo.sv
// Directed bench for rfdp_fifo (WIDTH=8, DEPTH=12, AF_THRESH=10) with a queue-based reference model.
module tb_rfdp_fifo;

   localparam int WIDTH = 8;
   localparam int DEPTH = 12;
   localparam int AF    = 10;
   localparam int LVL_W = $clog2(DEPTH + 3);
   localparam int BIG   = 1 << 30;

   logic             clk = 1'b0;
   logic             rst_n, flush, s_valid, s_ready, m_valid, m_ready, almost_full;
   logic [WIDTH-1:0] s_data, m_data;
   logic [LVL_W-1:0] level, max_level;

   int nchk  = 0;
   int nfail = 0;

   // Reference: words held in order, and the edge after which each is visible.
   logic [WIDTH-1:0] qd[$];
   int               qa[$];
   int               rd    = 0;
   int               ecnt  = 0;
   int               maxl  = 0;
   bit               mzero = 1'b0;

   logic             obs_pop, obs_push;
   logic [WIDTH-1:0] obs_d;

   always #5 clk = ~clk;

   rfdp_fifo #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .AF_THRESH(AF)
   ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .level      (level),
      .almost_full(almost_full),
      .max_level  (max_level)
   );

   task automatic chk(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, advance the model on the edge, compare at the falling edge.
   task automatic tick(input logic sv, input logic [WIDTH-1:0] sd, input logic mr,
                       input logic fl, input logic rn);
      bit pop, push, srdy, expv;
      s_valid = sv;
      s_data  = sd;
      m_ready = mr;
      flush   = fl;
      rst_n   = rn;
      #1;
      obs_pop  = m_valid & mr;
      obs_push = s_valid & s_ready;
      obs_d    = m_data;
      srdy = rn && !fl && ((qd.size() - rd) < DEPTH);
      pop  = mr && (qd.size() > 0) && (qa[0] <= ecnt);
      @(posedge clk);
      ecnt++;
      if (!rn || fl) begin
         qd.delete();
         qa.delete();
         rd   = 0;
         maxl = 0;
         if (!rn) mzero = 1'b1;
      end else begin
         push = sv && srdy;
         if ((rd < qd.size()) && ((rd - int'(pop)) < 2)) begin
            qa[rd] = ecnt + 1;
            rd++;
         end
         if (pop) begin
            void'(qd.pop_front());
            void'(qa.pop_front());
            rd--;
         end
         if (push) begin
            qd.push_back(sd);
            qa.push_back(BIG);
         end
         if (qd.size() > maxl) maxl = qd.size();
      end
      @(negedge clk);
      expv = (qd.size() > 0) && (qa[0] <= ecnt);
      chk("m_valid", int'(m_valid), int'(expv));
      if (expv) begin
         chk("m_data", int'(m_data), int'(qd[0]));
         mzero = 1'b0;
      end else if (mzero) begin
         chk("m_data_zero", int'(m_data), 0);
      end
      chk("level", int'(level), qd.size());
      chk("max_level", int'(max_level), maxl);
      chk("almost_full", int'(almost_full), int'(qd.size() >= AF));
      chk("s_ready", int'(s_ready), int'(rn && !fl && ((qd.size() - rd) < DEPTH)));
   endtask

   initial begin
      int sent, got;
      rst_n   = 1'b0;
      flush   = 1'b0;
      s_valid = 1'b0;
      m_ready = 1'b0;
      s_data  = '0;

      // Reset
      tick(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("rst_level", int'(level), 0);
      chk("rst_m_valid", int'(m_valid), 0);
      chk("rst_m_data", int'(m_data), 0);
      chk("rst_s_ready", int'(s_ready), 0);
      chk("rst_max_level", int'(max_level), 0);
      tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("s_ready_after_rst", int'(s_ready), 1);

      // Single push latency
      tick(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
      chk("lat_e0_m_valid", int'(m_valid), 0);
      chk("lat_e0_level", int'(level), 1);
      tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("lat_e1_m_valid", int'(m_valid), 0);
      tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("lat_e2_m_valid", int'(m_valid), 1);
      chk("lat_e2_m_data", int'(m_data), 'hA5);
      chk("lat_e2_level", int'(level), 1);
      tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      chk("empty_m_valid", int'(m_valid), 0);
      chk("empty_hold_m_data", int'(m_data), 'hA5);

      // Fill to capacity DEPTH+2, with almost_full crossing at 10
      for (int i = 0; i < 15; i++) begin
         tick(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
         if (i == 8)  begin chk("af_lvl9_level", int'(level), 9);  chk("af_lvl9", int'(almost_full), 0); end
         if (i == 9)  begin chk("af_lvl10_level", int'(level), 10); chk("af_lvl10", int'(almost_full), 1); end
         if (i == 12) chk("fill_s_ready_open", int'(s_ready), 1);
         if (i == 13) chk("fill_s_ready_closed", int'(s_ready), 0);
      end
      chk("full_level", int'(level), 14);
      chk("full_max_level", int'(max_level), 14);

      // Drain in order
      got = 0;
      for (int k = 0; k < 16; k++) begin
         tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
         if (obs_pop) begin
            chk("drain_order", int'(obs_d), got);
            got++;
         end
         if (k == 3) begin chk("drain_lvl10", int'(level), 10); chk("drain_af10", int'(almost_full), 1); end
         if (k == 4) begin chk("drain_lvl9", int'(level), 9);   chk("drain_af9", int'(almost_full), 0); end
      end
      chk("drain_count", got, 14);
      chk("drain_level", int'(level), 0);

      // Pointer wrap with m_ready pattern 1,1,0
      sent = 0;
      got  = 0;
      for (int c = 0; c < 400 && got < 100; c++) begin
         tick(sent < 100, 8'(sent + 16), (c % 3) != 2, 1'b0, 1'b1);
         if (obs_push) sent++;
         if (obs_pop) begin
            chk("wrap_order", int'(obs_d), got + 16);
            got++;
         end
      end
      chk("wrap_count", got, 100);
      chk("wrap_level", int'(level), 0);

      // Sustained push+pop
      for (int i = 0; i < 20; i++) begin
         tick(1'b1, 8'(200 + i), 1'b1, 1'b0, 1'b1);
         if (i >= 2) begin
            chk("steady_level", int'(level), 3);
            chk("steady_m_valid", int'(m_valid), 1);
         end
         if (i >= 3) begin
            chk("steady_pop", int'(obs_pop), 1);
            chk("steady_data", int'(obs_d), 200 + i - 3);
         end
      end
      repeat (6) tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      chk("steady_drained", int'(level), 0);

      // Flush with a read in flight and a push in the flush cycle
      for (int i = 0; i < 6; i++) tick(1'b1, 8'(50 + i), 1'b0, 1'b0, 1'b1);
      repeat (3) tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("pre_flush_level6", int'(level), 6);
      tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      chk("pre_flush_level5", int'(level), 5);
      chk("pre_flush_head", int'(m_data), 51);
      tick(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1);
      chk("flush_level", int'(level), 0);
      chk("flush_m_valid", int'(m_valid), 0);
      chk("flush_max_level", int'(max_level), 0);
      repeat (3) tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("flush_no_ghost", int'(m_valid), 0);
      tick(1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
      repeat (2) tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("post_flush_m_valid", int'(m_valid), 1);
      chk("post_flush_m_data", int'(m_data), 'h33);
      chk("post_flush_level", int'(level), 1);

      // Reset mid-operation also zeroes m_data
      tick(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
      tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("midrst_m_data", int'(m_data), 0);
      chk("midrst_m_valid", int'(m_valid), 0);
      chk("midrst_level", int'(level), 0);
      tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("midrst_s_ready", int'(s_ready), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule

// File: doc/rfdp_fifo.md
Name: rfdp_fifo

Overview:
- Parametrised single-clock FWFT (first-word-fall-through) FIFO built on a 1-write/1-read, read-latency-1 SRAM.
- Successor to the fixed-size rfdp buffers: generic width and depth, valid/ready handshakes on both sides, a 2-entry prefetch stage that hides the SRAM latency, occupancy and almost-full flags, a high-water mark, and synchronous flush.
- Sits between DNN feature/weight producers and PE-array consumers.

Parameters:
- WIDTH, 256, data word width in bits (≥1).
- DEPTH, 128, SRAM entries; any value ≥2, need not be a power of 2.
- AF_THRESH, DEPTH-8, almost_full asserts when level ≥ AF_THRESH.
- LVL_W, $clog2(DEPTH+3), width of level and max_level (derived, not overridable).

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, synchronous, active-low reset.
- flush, input, 1, synchronous clear of contents.
- s_valid, input, 1, write request.
- s_ready, output, 1, write acceptance.
- s_data, input, WIDTH, write data.
- m_valid, output, 1, head word valid.
- m_ready, input, 1, consumer pop.
- m_data, output, WIDTH, head word.
- level, output, LVL_W, total words held (SRAM + prefetch stage).
- almost_full, output, 1, level ≥ AF_THRESH.
- max_level, output, LVL_W, high-water mark since last reset or flush.

Behaviour:
- Capacity: DEPTH+2 words (SRAM plus 2-entry output stage). s_ready = (mem_cnt < DEPTH) & ~flush & rst_n.
- push = s_valid & s_ready. pop = m_valid & m_ready.
- Write pointer and read pointer are ADDR_W = $clog2(DEPTH) bits wide. Each wraps from DEPTH-1 to 0 (explicit compare, no modulo 2^ADDR_W).
- Push writes s_data at wr_ptr on the same edge. The SRAM port-B enable is active-low internally, as on the existing rfdp macros.
- Read issue: a read is issued at rd_ptr when mem_cnt ≠ 0 and (out_cnt + rd_inflight − pop) < 2.
- Read data returns one cycle after issue and enters the output stage in order. rd_inflight is a 1-bit register.
- Never issue a read to an address written on the same edge. mem_cnt counts only committed writes, so a word is readable no earlier than the edge after its write.
- Latency: a word pushed into an empty FIFO on edge E0 is read on E1, is captured on E2, and m_valid is high after E2.
- Throughput: one push and one pop per cycle sustained once the output stage is primed.
- Output stage: entry 0 drives m_data and m_valid. On pop, entry 1 shifts into entry 0. Return data goes to the lowest free entry after the shift.
- m_data holds its value while m_valid & ~m_ready (no change without a pop).
- Simultaneous push and pop: both take effect; level is unchanged.
- Full: s_ready=0 when mem_cnt = DEPTH; s_data is ignored.
- Empty: m_valid=0; m_data holds its last value.
- level = mem_cnt + out_cnt + rd_inflight, registered and updated every edge.
- almost_full is registered from the next-level value, so it is aligned with level.
- max_level updates to level_next when level_next > max_level.
- flush (rst_n high): on the edge, clear pointers, counts, rd_inflight, out_cnt and max_level, and set m_valid to 0. Data returning from an in-flight read is dropped. A push in the same cycle is discarded (s_ready is already 0). flush has priority over push and pop.
- Reset (rst_n low, sampled on edge):
  - m_valid=0, m_data=0, level=0, almost_full=0, max_level=0, pointers=0, s_ready=0.
  - s_ready=1 from the first cycle with rst_n high.
  - Reset mid-operation behaves as flush and also zeroes m_data.
- SRAM contents are never cleared; stale data is unreachable through the pointers.

Decomposition:
- Shared package rfdp_pkg:
  - function clog2_min1(n) for ADDR_W guards when DEPTH=1 is misused (elaboration $error if DEPTH<2);
  - typedef for the output-stage entry count (logic [1:0]).
- Sub-module: xilinx_1w1r_sram for storage.
  - WWORD=WIDTH, WADDR=ADDR_W, DEPTH=DEPTH.
  - clka and clkb both tied to clk.
  - Active-low cena/cenb driven from the read-issue and push signals.
- All pointer, count and output-stage logic stays in rfdp_fifo.

Test Plan:
- Reset then a single push of 0xA5 (WIDTH=8, DEPTH=16) with m_ready=0 → m_valid rises exactly 2 edges after the push edge; m_data=0xA5; level=1.
- Fill without pop (DEPTH=16): push 18 words 0..17 → s_ready drops after word 17 is accepted, level=18 and max_level=18; a 19th push is ignored. Then drain with m_ready=1 → data 0..17 in order, level ends at 0.
- DEPTH=12 wrap: stream 100 words with m_ready toggling on a 3-cycle pattern (1,1,0) → in-order output, no duplicates or losses; pointers wrap 11→0.
- Simultaneous push and pop at steady state (s_valid=m_ready=1 continuous) → 1 word per cycle, level stays constant at its primed value.
- flush asserted while rd_inflight=1 and level=5 → next cycle level=0, m_valid=0, max_level=0; a word pushed in the flush cycle never appears at the output.
- AF_THRESH=10: push up to level 9 → almost_full=0; push to level 10 → almost_full=1 on the same edge level shows 10; one pop → almost_full=0.
